// File: rtl/eva_ahb_cmd_master.sv
// AHB-Lite master engine: queued read/write commands are issued as pipelined
// SINGLE transfers with overlapped address/data phases. Each transfer returns a
// tagged response through a buffered response FIFO.
module eva_ahb_cmd_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TW        = 4
) (
  input  logic          hclk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [2:0]    cmd_size,
  input  logic [TW-1:0] cmd_tag,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic [TW-1:0] rsp_tag,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [AW-1:0] haddr,
  output logic [2:0]    hsize,
  output logic [2:0]    hburst,
  output logic [3:0]    hprot,
  output logic [DW-1:0] hwdata,
  input  logic          hready,
  input  logic          hresp,
  input  logic [DW-1:0] hrdata,
  output logic          busy
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam logic [CPW:0]   CMD_FULL  = (CPW+1)'(CMD_DEPTH);
  localparam logic [RPW:0]   RSP_FULL  = (RPW+1)'(RSP_DEPTH);
  localparam logic [RPW+1:0] RSP_LIMIT = (RPW+2)'(RSP_DEPTH);
  localparam logic [2:0]     SIZE_MAX  = 3'($clog2(DW/8));

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_NONSEQ = 2'b10
  } trans_e;

  // Command FIFO storage and pointers
  logic          cmd_mem_write [CMD_DEPTH];
  logic [AW-1:0] cmd_mem_addr  [CMD_DEPTH];
  logic [DW-1:0] cmd_mem_wdata [CMD_DEPTH];
  logic [2:0]    cmd_mem_size  [CMD_DEPTH];
  logic [TW-1:0] cmd_mem_tag   [CMD_DEPTH];
  logic [CPW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CPW:0]   cmd_cnt_q, cmd_cnt_d, cmd_left;

  // Response FIFO storage and pointers
  logic          rsp_mem_write [RSP_DEPTH];
  logic          rsp_mem_err   [RSP_DEPTH];
  logic [DW-1:0] rsp_mem_rdata [RSP_DEPTH];
  logic [TW-1:0] rsp_mem_tag   [RSP_DEPTH];
  logic [RPW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RPW:0]   rsp_cnt_q, rsp_cnt_d;

  // Address phase (AHB outputs) and data phase registers
  trans_e        htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [2:0]    hsize_q, hsize_d;
  logic          dph_valid_q, dph_valid_d;
  logic          dph_write_q, dph_write_d;
  logic [TW-1:0] dph_tag_q, dph_tag_d;
  logic [DW-1:0] dph_wdata_q, dph_wdata_d;

  logic cmd_push, cmd_pop, rsp_push, rsp_pop, aph_valid;
  logic [RPW+1:0] credit_used;

  // Handshakes and FIFO pointer/count bookkeeping
  always_comb begin
    aph_valid = (htrans_q == TR_NONSEQ);
    cmd_push  = cmd_valid && cmd_ready;
    cmd_pop   = hready && aph_valid;
    rsp_push  = hready && dph_valid_q;
    rsp_pop   = rsp_valid && rsp_ready;
    cmd_wr_d  = cmd_wr_q + CPW'(cmd_push);
    cmd_rd_d  = cmd_rd_q + CPW'(cmd_pop);
    cmd_cnt_d = cmd_cnt_q + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);
    cmd_left  = cmd_cnt_q - (CPW+1)'(cmd_pop);
    rsp_wr_d  = rsp_wr_q + RPW'(rsp_push);
    rsp_rd_d  = rsp_rd_q + RPW'(rsp_pop);
    rsp_cnt_d = rsp_cnt_q + (RPW+1)'(rsp_push) - (RPW+1)'(rsp_pop);
  end

  // Pipeline advance: data phase captures the accepted head, address phase
  // presents the next head only while a response slot is guaranteed for it
  always_comb begin
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    dph_valid_d = dph_valid_q;
    dph_write_d = dph_write_q;
    dph_tag_d   = dph_tag_q;
    dph_wdata_d = dph_wdata_q;
    credit_used = '0;
    if (hready) begin
      dph_valid_d = aph_valid;
      if (aph_valid) begin
        dph_write_d = cmd_mem_write[cmd_rd_q];
        dph_tag_d   = cmd_mem_tag[cmd_rd_q];
        dph_wdata_d = cmd_mem_wdata[cmd_rd_q];
      end
      // Credit counts the future response FIFO fill plus the data phase,
      // so every presented transfer already owns a response slot.
      credit_used = (RPW+2)'(rsp_cnt_d) + (RPW+2)'(dph_valid_d);
      if ((cmd_left != '0) && (credit_used < RSP_LIMIT)) begin
        htrans_d = TR_NONSEQ;
        hwrite_d = cmd_mem_write[cmd_rd_d];
        haddr_d  = cmd_mem_addr[cmd_rd_d];
        hsize_d  = cmd_mem_size[cmd_rd_d];
      end else begin
        htrans_d = TR_IDLE;
      end
    end else if (hresp) begin
      // First ERROR cycle: withdraw the pending address, it stays queued.
      htrans_d = TR_IDLE;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_cnt_q   <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      haddr_q     <= '0;
      hsize_q     <= '0;
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      dph_tag_q   <= '0;
      dph_wdata_q <= '0;
    end else begin
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_cnt_q   <= cmd_cnt_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_cnt_q   <= rsp_cnt_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
      dph_tag_q   <= dph_tag_d;
      dph_wdata_q <= dph_wdata_d;
    end
  end

  // Command FIFO write port
  always_ff @(posedge hclk) begin
    if (rst_n && cmd_push) begin
      cmd_mem_write[cmd_wr_q] <= cmd_write;
      cmd_mem_addr[cmd_wr_q]  <= cmd_addr;
      cmd_mem_wdata[cmd_wr_q] <= cmd_wdata;
      cmd_mem_size[cmd_wr_q]  <= cmd_size;
      cmd_mem_tag[cmd_wr_q]   <= cmd_tag;
    end
  end

  // Response FIFO write port; read data is zeroed for writes and errors
  always_ff @(posedge hclk) begin
    if (rst_n && rsp_push) begin
      rsp_mem_write[rsp_wr_q] <= dph_write_q;
      rsp_mem_err[rsp_wr_q]   <= hresp;
      rsp_mem_rdata[rsp_wr_q] <= (dph_write_q || hresp) ? '0 : hrdata;
      rsp_mem_tag[rsp_wr_q]   <= dph_tag_q;
    end
  end

  // Simulation checks: no response overflow, no oversized commands
  always_ff @(posedge hclk) begin
    if (rst_n) begin
      assert (!(rsp_push && !rsp_pop && (rsp_cnt_q == RSP_FULL)));
      assert (!(cmd_push && (cmd_size > SIZE_MAX)));
    end
  end

  assign cmd_ready = (cmd_cnt_q != CMD_FULL);
  assign rsp_valid = (rsp_cnt_q != '0);
  assign rsp_write = rsp_mem_write[rsp_rd_q];
  assign rsp_err   = rsp_mem_err[rsp_rd_q];
  assign rsp_rdata = rsp_mem_rdata[rsp_rd_q];
  assign rsp_tag   = rsp_mem_tag[rsp_rd_q];
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign haddr     = haddr_q;
  assign hsize     = hsize_q;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hwdata    = dph_wdata_q;
  assign busy      = (cmd_cnt_q != '0) || aph_valid || dph_valid_q || (rsp_cnt_q != '0);

endmodule

// File: tb/tb_eva_ahb_cmd_master.sv
// Directed bench for eva_ahb_cmd_master with a minimal AHB slave data model.
module tb_eva_ahb_cmd_master;

  logic        hclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [2:0]  cmd_size = 3'd2;
  logic [3:0]  cmd_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_tag;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;
  logic        busy;

  typedef logic [37:0] rsp_t;  // {write, err, rdata, tag}
  rsp_t got[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  logic auto_rdata = 1'b1;

  eva_ahb_cmd_master dut (
    .hclk(hclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .busy(busy)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic rsp_t mk(input logic w, input logic e, input logic [31:0] d, input logic [3:0] t);
    return {w, e, d, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int idx, input rsp_t exp);
    rsp_t v;
    v = (idx < got.size()) ? got[idx] : 'x;
    chk($sformatf("%s_rsp%0d", tag, idx), 64'(v), 64'(exp));
  endtask

  // One clock: collect responses and accepted addresses, then model read data
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    acc = (htrans == 2'b10) && hready;
    acc_addr = haddr;
    if (rsp_valid === 1'b1 && rsp_ready) got.push_back({rsp_write, rsp_err, rsp_rdata, rsp_tag});
    if (acc === 1'b1) n_acc++;
    @(posedge hclk);
    #1;
    if (acc === 1'b1 && auto_rdata) hrdata = 32'hC0DE0000 | acc_addr;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    int   guard;
    logic hs;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = 3'd2; cmd_tag = t;
    guard = 0;
    do begin
      hs = cmd_ready;
      step();
      guard++;
    end while (!hs && guard < 50);
    if (!hs) chk("push_timeout", 64'(hs), 64'd1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_hwrite", 64'(hwrite), 64'd0);
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_hwdata", 64'(hwdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Single write, tag 3
    got.delete();
    push(1'b1, 32'h1000, 32'hDEADBEEF, 4'd3);
    chk("t1_idle_after_push", 64'(htrans), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    step();
    chk("t1_nonseq", 64'(htrans), 64'h2);
    chk("t1_haddr", 64'(haddr), 64'h1000);
    chk("t1_hwrite", 64'(hwrite), 64'd1);
    chk("t1_hsize", 64'(hsize), 64'd2);
    chk("t1_hburst", 64'(hburst), 64'd0);
    chk("t1_hprot", 64'(hprot), 64'h3);
    step();
    chk("t1_idle_dphase", 64'(htrans), 64'd0);
    chk("t1_hwdata", 64'(hwdata), 64'hDEADBEEF);
    chk("t1_rsp_not_yet", 64'(rsp_valid), 64'd0);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_write", 64'(rsp_write), 64'd1);
    chk("t1_rsp_err", 64'(rsp_err), 64'd0);
    chk("t1_rsp_tag", 64'(rsp_tag), 64'd3);
    chk("t1_rsp_rdata", 64'(rsp_rdata), 64'd0);
    step();
    chk("t1_rsp_popped", 64'(rsp_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Four back-to-back reads, zero wait states
    got.delete();
    push(1'b0, 32'h0, 32'h0, 4'd0);
    push(1'b0, 32'h4, 32'h0, 4'd1);
    chk("t2_ns0", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h0});
    push(1'b0, 32'h8, 32'h0, 4'd2);
    chk("t2_ns1", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h4});
    push(1'b0, 32'hC, 32'h0, 4'd3);
    chk("t2_ns2", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h8});
    step();
    chk("t2_ns3", 64'({htrans, haddr}), {30'd0, 2'b10, 32'hC});
    step();
    chk("t2_idle", 64'(htrans), 64'd0);
    for (int i = 0; i < 4; i++) step();
    chk("t2_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk_rsp("t2", i, mk(1'b0, 1'b0, 32'hC0DE0000 | 32'(4 * i), 4'(i)));

    // Read with three wait states while the next read waits in address phase
    got.delete();
    auto_rdata = 1'b0;
    push(1'b0, 32'h20, 32'h0, 4'd7);
    push(1'b0, 32'h24, 32'h0, 4'd8);
    chk("t3_ns_first", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h20});
    step();
    chk("t3_ns_second", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h24});
    hready = 1'b0;
    hrdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_hold%0d", i), 64'({htrans, haddr}), {30'd0, 2'b10, 32'h24});
    end
    hready = 1'b1;
    hrdata = 32'h600DF00D;
    step();
    hrdata = 32'h12345678;
    step(); step(); step();
    auto_rdata = 1'b1;
    chk("t3_count", 64'(got.size()), 64'd2);
    chk_rsp("t3", 0, mk(1'b0, 1'b0, 32'h600DF00D, 4'd7));
    chk_rsp("t3", 1, mk(1'b0, 1'b0, 32'h12345678, 4'd8));

    // ERROR on write tag 5 while read tag 6 waits in address phase
    got.delete();
    push(1'b1, 32'h40, 32'hCAFE0005, 4'd5);
    push(1'b0, 32'h44, 32'h0, 4'd6);
    chk("t4_ns_write", 64'({hwrite, htrans, haddr}), {29'd0, 1'b1, 2'b10, 32'h40});
    step();
    chk("t4_ns_read", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h44});
    chk("t4_hwdata", 64'(hwdata), 64'hCAFE0005);
    hready = 1'b0;
    hresp = 1'b1;
    step();
    chk("t4_idle_err2", 64'(htrans), 64'd0);
    hready = 1'b1;
    step();
    hresp = 1'b0;
    chk("t4_reissue", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h44});
    chk("t4_err_rsp", 64'({rsp_valid, rsp_err, rsp_tag}), {58'd0, 1'b1, 1'b1, 4'd5});
    for (int i = 0; i < 4; i++) step();
    chk("t4_count", 64'(got.size()), 64'd2);
    chk_rsp("t4", 0, mk(1'b1, 1'b1, 32'h0, 4'd5));
    chk_rsp("t4", 1, mk(1'b0, 1'b0, 32'hC0DE0044, 4'd6));

    // Response back-pressure: only RSP_DEPTH transfers may be outstanding
    got.delete();
    n_acc = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'(i));
    for (int i = 0; i < 5; i++) step();
    chk("t5_issued", 64'(n_acc), 64'd4);
    chk("t5_idle", 64'(htrans), 64'd0);
    chk("t5_cmd_full", 64'(cmd_ready), 64'd0);
    chk("t5_rsp_held", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && got.size() < 8; i++) step();
    step(); step();
    chk("t5_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk_rsp("t5", i, mk(1'b0, 1'b0, 32'hC0DE0100 + 32'(4 * i), 4'(i)));
    chk("t5_drained", 64'(busy), 64'd0);

    // Reset with two commands queued and one transfer in data phase
    got.delete();
    push(1'b0, 32'h200, 32'h0, 4'd9);
    push(1'b0, 32'h204, 32'h0, 4'd10);
    push(1'b0, 32'h208, 32'h0, 4'd11);
    chk("t6_pre_ns", 64'({htrans, haddr}), {30'd0, 2'b10, 32'h204});
    rst_n = 1'b0;
    step();
    chk("t6_htrans", 64'(htrans), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_stale", 64'(got.size()), 64'd0);
    chk("t6_still_idle", 64'({busy, htrans}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
